// File: rtl/countdown_timer.sv
// Programmable down-counter with optional prescaler and auto-reload.
// Loaded with a duration, counts down while count_i is high, and flags expiry.
module countdown_timer #(
    parameter int WIDTH       = 8,
    parameter int PRESCALE    = 1,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             count_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] time_o,
    output logic             running_o,
    output logic             expired_o,
    output logic             done_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] time_q, time_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             expired_q, expired_d;

    // State and datapath registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            time_q    <= '0;
            reload_q  <= '0;
            presc_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            reload_q  <= reload_d;
            presc_q   <= presc_d;
            expired_q <= expired_d;
        end
    end

    // Next-state: clear beats load beats counting; expiry pulse only from a real decrement
    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        reload_d  = reload_q;
        presc_d   = presc_q;
        expired_d = 1'b0;
        if (clear_i) begin
            state_d = ST_IDLE;
            time_d  = '0;
            presc_d = '0;
        end else if (load_i) begin
            reload_d = load_val_i;
            time_d   = load_val_i;
            presc_d  = '0;
            if (load_val_i != '0) begin
                state_d = ST_ARMED;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_ARMED: begin
                    if (count_i) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_RUN: begin
                    if (!count_i) begin
                        state_d = ST_ARMED;
                    end else if (presc_q == PRE_LAST) begin
                        presc_d = '0;
                        if (time_q > WIDTH'(1)) begin
                            time_d = time_q - WIDTH'(1);
                        end else if (time_q == WIDTH'(1)) begin
                            expired_d = 1'b1;
                            if (AUTO_RELOAD != 0) begin
                                time_d = reload_q;
                            end else begin
                                time_d  = '0;
                                state_d = ST_DONE;
                            end
                        end else begin
                            time_d = '0;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign time_o    = time_q;
    assign running_o = (state_q == ST_RUN);
    assign done_o    = (state_q == ST_DONE);
    assign expired_o = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: three parameterisations share the same stimulus and are
// compared each cycle against a tick-accumulating reference model.
module tb_countdown_timer;

    localparam int N = 3;
    localparam int P_PRE [N] = '{1, 1, 4};
    localparam int P_AR  [N] = '{0, 1, 0};
    localparam int M_IDLE = 0, M_WAIT = 1, M_GO = 2, M_FIN = 3;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       load_i = 1'b0, count_i = 1'b0, clear_i = 1'b0;
    logic [7:0] load_val_i = 8'd0;
    logic [7:0] t_o [N];
    logic       run_o [N], exp_o [N], done_o [N];

    int n_checks = 0, n_pass = 0;

    // reference model state, one entry per instance
    int m_rem [N], m_reload [N], m_acc [N], m_mode [N];
    bit m_exp [N];

    always #5 clk_i = ~clk_i;

    countdown_timer #(.WIDTH(8), .PRESCALE(1), .AUTO_RELOAD(0)) u_plain (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(load_i), .load_val_i(load_val_i),
        .count_i(count_i), .clear_i(clear_i), .time_o(t_o[0]), .running_o(run_o[0]),
        .expired_o(exp_o[0]), .done_o(done_o[0]));
    countdown_timer #(.WIDTH(8), .PRESCALE(1), .AUTO_RELOAD(1)) u_reload (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(load_i), .load_val_i(load_val_i),
        .count_i(count_i), .clear_i(clear_i), .time_o(t_o[1]), .running_o(run_o[1]),
        .expired_o(exp_o[1]), .done_o(done_o[1]));
    countdown_timer #(.WIDTH(8), .PRESCALE(4), .AUTO_RELOAD(0)) u_presc (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(load_i), .load_val_i(load_val_i),
        .count_i(count_i), .clear_i(clear_i), .time_o(t_o[2]), .running_o(run_o[2]),
        .expired_o(exp_o[2]), .done_o(done_o[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_rem[k] = 0; m_reload[k] = 0; m_acc[k] = 0; m_mode[k] = M_IDLE; m_exp[k] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit clr, input bit ld, input int val, input bit cnt);
        for (int k = 0; k < N; k++) begin
            m_exp[k] = 1'b0;
            if (clr) begin
                m_rem[k] = 0; m_acc[k] = 0; m_mode[k] = M_IDLE;
            end else if (ld) begin
                m_reload[k] = val; m_rem[k] = val; m_acc[k] = 0;
                m_mode[k] = (val != 0) ? M_WAIT : M_IDLE;
            end else if (m_mode[k] == M_WAIT && cnt) begin
                m_mode[k] = M_GO;
            end else if (m_mode[k] == M_GO && !cnt) begin
                m_mode[k] = M_WAIT;
            end else if (m_mode[k] == M_GO) begin
                m_acc[k] += 1;
                if (m_acc[k] == P_PRE[k]) begin
                    m_acc[k] = 0;
                    m_rem[k] -= 1;
                    if (m_rem[k] == 0) begin
                        m_exp[k] = 1'b1;
                        if (P_AR[k] != 0) m_rem[k] = m_reload[k];
                        else m_mode[k] = M_FIN;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < N; k++) begin
            check($sformatf("time[%0d]", k), 32'(t_o[k]), 32'(m_rem[k]));
            check($sformatf("running[%0d]", k), 32'(run_o[k]), 32'(m_mode[k] == M_GO));
            check($sformatf("expired[%0d]", k), 32'(exp_o[k]), 32'(m_exp[k]));
            check($sformatf("done[%0d]", k), 32'(done_o[k]), 32'(m_mode[k] == M_FIN));
        end
    endtask

    // drive one cycle of inputs, advance the model at the edge, check just after it
    task automatic step(input bit clr, input bit ld, input int val, input bit cnt);
        clear_i = clr; load_i = ld; load_val_i = 8'(val); count_i = cnt;
        @(posedge clk_i);
        model_edge(clr, ld, val, cnt);
        #1;
        check_all();
    endtask

    // reset asserted mid-cycle; outputs must drop before any further edge
    task automatic async_reset();
        @(negedge clk_i);
        #2;
        reset_i = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        reset_i = 1'b0;
        @(negedge clk_i);

        // load 3 with count held: 3,3,2,1,0 then done stays
        step(0, 1, 3, 1); check("t1_load", 32'(t_o[0]), 32'd3);
        step(0, 0, 0, 1); check("t1_arm", 32'(t_o[0]), 32'd3);
        step(0, 0, 0, 1); check("t1_dec2", 32'(t_o[0]), 32'd2);
        step(0, 0, 0, 1); check("t1_dec1", 32'(t_o[0]), 32'd1);
        step(0, 0, 0, 1); check("t1_zero", 32'(t_o[0]), 32'd0);
        check("t1_exp", 32'(exp_o[0]), 32'd1);
        step(0, 0, 0, 1); check("t1_exp_off", 32'(exp_o[0]), 32'd0);
        check("t1_done", 32'(done_o[0]), 32'd1);

        // pause and resume
        step(0, 1, 10, 0);
        repeat (4) step(0, 0, 0, 1);
        check("t2_before_pause", 32'(t_o[0]), 32'd7);
        repeat (3) step(0, 0, 0, 0);
        check("t2_hold", 32'(t_o[0]), 32'd7);
        check("t2_paused", 32'(run_o[0]), 32'd0);
        step(0, 0, 0, 1); check("t2_resume1", 32'(t_o[0]), 32'd7);
        step(0, 0, 0, 1); check("t2_resume2", 32'(t_o[0]), 32'd6);

        // async reset after two decrements
        step(0, 1, 5, 1);
        repeat (3) step(0, 0, 0, 1);
        check("t3_pre", 32'(t_o[0]), 32'd3);
        async_reset();

        // clear+load on an expiry edge, then load 0
        step(0, 1, 2, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1); check("t4_at1", 32'(t_o[0]), 32'd1);
        step(1, 1, 9, 1);
        check("t4_clr_time", 32'(t_o[0]), 32'd0);
        check("t4_clr_exp", 32'(exp_o[0]), 32'd0);
        step(0, 1, 0, 1);
        check("t4_load0_exp", 32'(exp_o[0]), 32'd0);
        check("t4_load0_time", 32'(t_o[0]), 32'd0);

        // auto reload sequence and prescaled sequence
        step(0, 1, 2, 0);
        step(0, 0, 0, 1); // edge n
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 0, 1);
            if (i == 2) check("t5_reload", 32'(t_o[1]), 32'd2);
            if (i == 4) check("t6_n4", 32'(t_o[2]), 32'd1);
            if (i == 8) check("t6_n8", 32'(t_o[2]), 32'd0);
            if (i == 8) check("t6_exp", 32'(exp_o[2]), 32'd1);
        end
        check("t5_no_done", 32'(done_o[1]), 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 24) == 0, $urandom_range(0, 9) == 0,
                     ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                                 : int'($urandom_range(0, 6)),
                     $urandom_range(0, 3) != 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
